dcache_controller: RTL
======================

# dcache_controller

Sequencing FSM for the data-cache register array: accepts one 64-bit load/store request at a time from the core and drives the array's read address and write port. Load misses are refilled from memory, with a full block written into the array. Stores are write-through and no-write-allocate; a store hit also updates the cached double word. The block sits between the memory-stage request interface and the array and memory interconnect, one outstanding request at a time.

## Interface
- `double_word_offset_width`, default 3: log2 of double words per block; block_bits = 64<<double_word_offset_width.
- `line_width`, default 6: log2 of lines; tag_width = 32-double_word_offset_width-3-line_width (20 by default).
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clock`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  core request valid.
- `req_ready`  out  1  controller can accept a request.
- `req_address`  in  32  byte address; bits [2:0] ignored.
- `req_is_store`  in  1  1 = store, 0 = load.
- `req_wdata`  in  64  store data.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  core accepts response.
- `resp_data`  out  64  load data; 0 for stores.
- `array_address`  out  32  read address to array (array output registered, 1-cycle latency).
- `array_data`  in  64  array double word read.
- `array_tag`  in  tag_width  array tag read.
- `array_tag_valid`  in  1  array valid bit read.
- `array_reset`  out  1  synchronous clear of all array valid bits.
- `array_write_in`  out  1  array write strobe.
- `array_write_line_index`  out  line_width  line written.
- `array_write_block`  out  block_bits  block data.
- `array_write_tag`  out  tag_width  tag written.
- `array_write_mask`  out  block_size  per-double-word enables.
- `mem_rd_valid` / `mem_rd_ready`  out/in  1  refill request handshake.
- `mem_rd_addr`  out  32  block-aligned address; low double_word_offset_width+3 bits are 0.
- `mem_rd_resp_valid`  in  1  refill data present for one cycle.
- `mem_rd_resp_block`  in  block_bits  refill block; double word j is at [64j +: 64].
- `mem_wr_valid` / `mem_wr_ready`  out/in  1  write-through handshake.
- `mem_wr_addr`  out  32  double-word-aligned address.
- `mem_wr_data`  out  64  store data.

## Operation
- Address fields: offset = addr[double_word_offset_width+2:3]; line = addr[line_width+double_word_offset_width+2:double_word_offset_width+3]; tag = addr[31:32-tag_width].
- The address, store flag and wdata are latched on acceptance. `array_address` = `req_address` in IDLE, otherwise the latched address.
- `hit` = array_tag_valid && array_tag == latched tag, evaluated in LOOKUP only.
- INIT: array_reset=1; next state IDLE.
- IDLE: req_ready=1. On req_valid, latch the request and go to LOOKUP.
- LOOKUP, load hit: register resp_data=array_data; go to RESP.
- LOOKUP, load miss: go to MISS_REQ.
- LOOKUP, store: go to STORE_REQ. On a hit, also assert array_write_in in this cycle with mask = one-hot(offset), write_block = wdata replicated in every slot, tag = latched tag, line = latched line. A store miss writes nothing to the array.
- MISS_REQ: mem_rd_valid=1. When mem_rd_ready is also 1, go to MISS_WAIT.
- MISS_WAIT: on mem_rd_resp_valid, assert array_write_in with mask all-ones, block = resp block and the latched tag and line. In the same cycle register resp_data = resp block slot [offset] and go to RESP.
- STORE_REQ: mem_wr_valid=1. When mem_wr_ready is also 1, register resp_data=0 and go to RESP.
- RESP: resp_valid=1 with resp_data stable. When resp_ready is also 1, go to IDLE.
- mem_rd_valid and mem_wr_valid, once raised, stay high with stable address/data until accepted.
- array_write_in is never asserted outside LOOKUP (store hit) and MISS_WAIT (refill).
- A refill overwrites any valid line at that index; there is no writeback because the cache is write-through.

## Timing
- On reset (async assert): state=INIT. req_ready=0, resp_valid=0, resp_data=0, mem_rd_valid=0, mem_wr_valid=0, array_write_in=0, array_reset=1.
- INIT lasts exactly one clock after reset_n deasserts; req_ready first rises in the following cycle.
- Load hit: accept at cycle 0, LOOKUP at 1, resp_valid at 2. Best case 3 cycles from accept to IDLE.
- Load miss: resp_valid one cycle after mem_rd_resp_valid.
- Store: resp_valid one cycle after the mem_wr handshake.
- A mem_rd_resp_valid pulse arriving before MISS_WAIT is ignored; the memory side must not respond before its request is accepted.
- Back-to-back: a new request is accepted in the first IDLE cycle after the RESP handshake. A load to the same line that was just refilled or stored hits.
- Reset mid-operation (any state) aborts immediately: in-flight memory transactions are dropped and the array is invalidated. The memory side shares reset_n.

## Test plan
- Reset, then load 0x0000_1008. Expect INIT clears valid bits, then a miss: mem_rd_addr=0x0000_1000. Return block with slot j = j. Expect resp_data=1 and a full-mask write to line 0, tag 0x00001.
- Repeat the load to 0x0000_1008. Expect a hit: no mem_rd_valid, resp_valid exactly 2 cycles after accept, data=1.
- Store 0xDEAD_BEEF_0000_0005 to 0x0000_1010 (hit). Expect array write mask 0x04 and mem_wr_addr=0x0000_1010. A subsequent load of that address returns the stored value.
- Store to 0x0000_2010 (miss). Expect mem_wr only and no array_write_in. A later load of that address misses.
- Hold mem_rd_ready=0 for 5 cycles and resp_ready=0 for 3 cycles. Expect mem_rd_valid/addr and resp_valid/data to stay stable, and no new request accepted.
- Assert reset_n=0 during MISS_WAIT. Expect all valids to drop at once; after release, the previously refilled line misses.

Source files
------------

// File: rtl/dcache_if.sv
// Bundle of the data-cache controller's core, array and memory signals.
// The controller takes the slave view; the core/array/memory environment takes the master view.
interface dcache_if #(
  parameter int double_word_offset_width = 3,
  parameter int line_width               = 6
);
  localparam int tag_width  = 32 - double_word_offset_width - 3 - line_width;
  localparam int block_size = 1 << double_word_offset_width;
  localparam int block_bits = 64 << double_word_offset_width;

  // Core request/response
  logic                  req_valid;
  logic                  req_ready;
  logic [31:0]           req_address;
  logic                  req_is_store;
  logic [63:0]           req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [63:0]           resp_data;

  // Register array
  logic [31:0]           array_address;
  logic [63:0]           array_data;
  logic [tag_width-1:0]  array_tag;
  logic                  array_tag_valid;
  logic                  array_reset;
  logic                  array_write_in;
  logic [line_width-1:0] array_write_line_index;
  logic [block_bits-1:0] array_write_block;
  logic [tag_width-1:0]  array_write_tag;
  logic [block_size-1:0] array_write_mask;

  // Memory interconnect
  logic                  mem_rd_valid;
  logic                  mem_rd_ready;
  logic [31:0]           mem_rd_addr;
  logic                  mem_rd_resp_valid;
  logic [block_bits-1:0] mem_rd_resp_block;
  logic                  mem_wr_valid;
  logic                  mem_wr_ready;
  logic [31:0]           mem_wr_addr;
  logic [63:0]           mem_wr_data;

  modport slave (
    input  req_valid, req_address, req_is_store, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_data,
    input  array_data, array_tag, array_tag_valid,
    output array_address, array_reset, array_write_in, array_write_line_index,
    output array_write_block, array_write_tag, array_write_mask,
    input  mem_rd_ready, mem_rd_resp_valid, mem_rd_resp_block, mem_wr_ready,
    output mem_rd_valid, mem_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data
  );

  modport master (
    output req_valid, req_address, req_is_store, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_data,
    output array_data, array_tag, array_tag_valid,
    input  array_address, array_reset, array_write_in, array_write_line_index,
    input  array_write_block, array_write_tag, array_write_mask,
    output mem_rd_ready, mem_rd_resp_valid, mem_rd_resp_block, mem_wr_ready,
    input  mem_rd_valid, mem_rd_addr, mem_wr_valid, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/dcache_controller.sv
// Write-through, no-write-allocate data-cache sequencer: one request at a time,
// load misses refill a whole block, stores go straight to memory.
module dcache_controller #(
  parameter int double_word_offset_width = 3,
  parameter int line_width               = 6
) (
  input  logic       clock,
  input  logic       reset_n,
  dcache_if.slave    bus,
  output logic [2:0] dbg_state_o
);
  localparam int DWO    = double_word_offset_width;
  localparam int LW     = line_width;
  localparam int TAG_W  = 32 - DWO - 3 - LW;
  localparam int BS     = 1 << DWO;
  localparam int BB     = 64 << DWO;

  // Handshakes: a transfer happens on a rising edge where valid && ready; the
  // source raises valid without looking at ready and holds valid and payload
  // unchanged until that edge.
  typedef enum logic [2:0] {
    S_INIT      = 3'd0,
    S_IDLE      = 3'd1,
    S_LOOKUP    = 3'd2,
    S_MISS_REQ  = 3'd3,
    S_MISS_WAIT = 3'd4,
    S_STORE_REQ = 3'd5,
    S_RESP      = 3'd6
  } state_e;

  state_e      state_q, state_d;
  logic [28:0] addr_q, addr_d;       // double-word address, byte bits dropped
  logic        is_store_q, is_store_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] resp_data_q, resp_data_d;

  logic [DWO-1:0]   offset_q;
  logic [LW-1:0]    line_q;
  logic [TAG_W-1:0] tag_q;
  logic             hit;

  assign offset_q = addr_q[DWO-1:0];
  assign line_q   = addr_q[LW+DWO-1:DWO];
  assign tag_q    = addr_q[28 -: TAG_W];
  assign hit      = bus.array_tag_valid && (bus.array_tag == tag_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q      <= '0;
      is_store_q  <= 1'b0;
      wdata_q     <= '0;
      resp_data_q <= '0;
    end else begin
      addr_q      <= addr_d;
      is_store_q  <= is_store_d;
      wdata_q     <= wdata_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    is_store_d  = is_store_q;
    wdata_d     = wdata_q;
    resp_data_d = resp_data_q;
    case (state_q)
      S_INIT: state_d = S_IDLE;
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d     = bus.req_address[31:3];
          is_store_d = bus.req_is_store;
          wdata_d    = bus.req_wdata;
          state_d    = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (is_store_q) begin
          state_d = S_STORE_REQ;
        end else if (hit) begin
          resp_data_d = bus.array_data;
          state_d     = S_RESP;
        end else begin
          state_d = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        if (bus.mem_rd_ready) state_d = S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        if (bus.mem_rd_resp_valid) begin
          resp_data_d = bus.mem_rd_resp_block[64*offset_q +: 64];
          state_d     = S_RESP;
        end
      end
      S_STORE_REQ: begin
        if (bus.mem_wr_ready) begin
          resp_data_d = '0;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    bus.req_ready         = 1'b0;
    bus.resp_valid        = 1'b0;
    bus.array_reset       = 1'b0;
    bus.mem_rd_valid      = 1'b0;
    bus.mem_wr_valid      = 1'b0;
    bus.array_write_in    = 1'b0;
    bus.array_write_mask  = '0;
    bus.array_write_block = '0;
    case (state_q)
      S_INIT:      bus.array_reset  = 1'b1;
      S_IDLE:      bus.req_ready    = 1'b1;
      S_LOOKUP: begin
        // Store hit keeps the cached copy coherent with the write-through.
        if (is_store_q && hit) begin
          bus.array_write_in    = 1'b1;
          bus.array_write_mask  = BS'(1) << offset_q;
          bus.array_write_block = {BS{wdata_q}};
        end
      end
      S_MISS_REQ:  bus.mem_rd_valid = 1'b1;
      S_MISS_WAIT: begin
        if (bus.mem_rd_resp_valid) begin
          bus.array_write_in    = 1'b1;
          bus.array_write_mask  = '1;
          bus.array_write_block = bus.mem_rd_resp_block;
        end
      end
      S_STORE_REQ: bus.mem_wr_valid = 1'b1;
      S_RESP:      bus.resp_valid   = 1'b1;
      default:     bus.array_reset  = 1'b1;
    endcase
  end

  assign bus.array_address          = (state_q == S_IDLE) ? bus.req_address : {addr_q, 3'b000};
  assign bus.resp_data              = resp_data_q;
  assign bus.array_write_line_index = line_q;
  assign bus.array_write_tag        = tag_q;
  assign bus.mem_rd_addr            = {addr_q[28:DWO], {(DWO+3){1'b0}}};
  assign bus.mem_wr_addr            = {addr_q, 3'b000};
  assign bus.mem_wr_data            = wdata_q;
  assign dbg_state_o                = state_q;

  logic unused_bb;
  assign unused_bb = (BB == 0);
endmodule
